// File: rtl/hamming_pkg.sv
// Shared definitions for the serial Hamming(15,11) link.
// Holds the code geometry, the data-position table, the syndrome function
// (shared with the encoder) and the receive FSM state type.
// Optional feature macro: HAMMING_SECDED_EN. When it is defined, each codeword
// carries a sixteenth bit holding overall even parity over bits 0..14.
package hamming_pkg;

  localparam int unsigned DATA_W = 11;
  localparam int unsigned PAR_W  = 4;
  // Number of Hamming positions (1..15) covered by the syndrome.
  localparam int unsigned HAM_W  = 15;
`ifdef HAMMING_SECDED_EN
  localparam int unsigned CODE_W = 16;
`else
  localparam int unsigned CODE_W = 15;
`endif

  // data bit k sits at Hamming position DATA_POS[k] (code bit index = position - 1)
  localparam logic [DATA_W-1:0][PAR_W-1:0] DATA_POS = {
    4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
  };

  // XOR of the positions of all set bits; zero for a valid codeword.
  function automatic logic [PAR_W-1:0] calc_syndrome(input logic [HAM_W-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < HAM_W; i++) begin
      if (cw[i]) s ^= PAR_W'(i + 1);
    end
    return s;
  endfunction

  typedef enum logic [1:0] {
    COLLECT,
    CHECK,
    HOLD
  } state_t;

endpackage

// File: rtl/hamming_syndrome_dec.sv
// Combinational syndrome, single-error correction and data extraction.
// Ports:
//   cw         in   CODE_W  received codeword, bit i = Hamming position i+1
//   data       out  DATA_W  corrected data bits
//   syndrome   out  PAR_W   raw syndrome of the received word
//   err_corr   out  1       a single error was corrected
//   err_uncorr out  1       double error detected (HAMMING_SECDED_EN only, else 0)
// Optional feature macro: HAMMING_SECDED_EN (adds overall-parity bit 15).
module hamming_syndrome_dec
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] cw,
  output logic [DATA_W-1:0] data,
  output logic [PAR_W-1:0]  syndrome,
  output logic              err_corr,
  output logic              err_uncorr
);

  logic [HAM_W-1:0] ham;
  logic [HAM_W-1:0] fixed;
  logic             do_flip;
`ifdef HAMMING_SECDED_EN
  logic             par_bad;
`endif

  always_comb begin
    ham        = cw[HAM_W-1:0];
    syndrome   = calc_syndrome(ham);
    fixed      = ham;
    do_flip    = 1'b0;
    err_corr   = 1'b0;
    err_uncorr = 1'b0;
    data       = '0;
`ifdef HAMMING_SECDED_EN
    // even parity over all 16 bits: any odd count of flips shows up here
    par_bad = ^cw;
    if (syndrome != '0) begin
      if (par_bad) begin
        do_flip  = 1'b1;
        err_corr = 1'b1;
      end else begin
        // two flips: syndrome points nowhere useful, pass data through raw
        err_uncorr = 1'b1;
      end
    end else if (par_bad) begin
      // only the overall parity bit is wrong; data is already intact
      err_corr = 1'b1;
    end
`else
    if (syndrome != '0) begin
      do_flip  = 1'b1;
      err_corr = 1'b1;
    end
`endif
    // syndrome value s names position s, i.e. code bit index s-1
    for (int unsigned i = 0; i < HAM_W; i++) begin
      if (do_flip && syndrome == PAR_W'(i + 1)) fixed[i] = ~ham[i];
    end
    for (int unsigned k = 0; k < DATA_W; k++) begin
      data[k] = fixed[DATA_POS[k] - 4'd1];
    end
  end

endmodule

// File: rtl/hamming_rx_deser.sv
// Receive end of the serial Hamming link: shifts in a codeword LSB-first,
// decodes/corrects it and presents the data with a valid/ready handshake.
// Ports:
//   clk        in   1       rising-edge clock
//   RST        in   1       synchronous active-low reset
//   ser_in     in   1       serial code bit
//   ser_valid  in   1       ser_in valid this cycle
//   ser_ready  out  1       a bit offered on this edge is accepted
//   sof        in   1       start of frame (qualified by ser_valid)
//   data_out   out  DATA_W  decoded, corrected data
//   out_valid  out  1       data_out/syndrome/flags valid
//   out_ready  in   1       consumer accepts the word
//   syndrome   out  PAR_W   raw syndrome
//   err_corr   out  1       single error corrected
//   err_uncorr out  1       uncorrectable error (0 unless HAMMING_SECDED_EN)
// Optional feature macro: HAMMING_SECDED_EN (16-bit SECDED codeword).
module hamming_rx_deser
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              RST,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic              ser_ready,
  input  logic              sof,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PAR_W-1:0]  syndrome,
  output logic              err_corr,
  output logic              err_uncorr
);

  localparam int unsigned CNT_W = $clog2(CODE_W + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CODE_W-1:0]  cw;

  logic [DATA_W-1:0]  dec_data;
  logic [PAR_W-1:0]   dec_syndrome;
  logic               dec_corr;
  logic               dec_uncorr;

  hamming_syndrome_dec u_dec (
    .cw         (cw),
    .data       (dec_data),
    .syndrome   (dec_syndrome),
    .err_corr   (dec_corr),
    .err_uncorr (dec_uncorr)
  );

  always_ff @(posedge clk) begin
    if (!RST) begin
      state      <= COLLECT;
      cnt        <= '0;
      cw         <= '0;
      data_out   <= '0;
      syndrome   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      out_valid  <= 1'b0;
      ser_ready  <= 1'b1;
    end else begin
      case (state)
        COLLECT: begin
          if (ser_valid) begin
            cw <= {ser_in, cw[CODE_W-1:1]};
            // sof wins over completion: a frame start on the would-be last bit
            // restarts the count and no CHECK follows. Stale bits are pushed
            // out by the CODE_W shifts that complete the new frame.
            if (sof) begin
              cnt <= CNT_W'(1);
            end else if (cnt == CNT_W'(CODE_W - 1)) begin
              cnt       <= '0;
              state     <= CHECK;
              ser_ready <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        CHECK: begin
          data_out   <= dec_data;
          syndrome   <= dec_syndrome;
          err_corr   <= dec_corr;
          err_uncorr <= dec_uncorr;
          out_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ser_ready <= 1'b1;
            state     <= COLLECT;
          end
        end
        default: begin
          state     <= COLLECT;
          ser_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_rx_deser.sv
// Scoreboard bench for hamming_rx_deser: stimulus pushes the hand-computed
// decode result, a negedge monitor compares while out_valid is high and pops
// on the handshake.
module tb_hamming_rx_deser;
  import hamming_pkg::*;

  logic              clk;
  logic              RST;
  logic              ser_in;
  logic              ser_valid;
  logic              ser_ready;
  logic              sof;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic [PAR_W-1:0]  syndrome;
  logic              err_corr;
  logic              err_uncorr;

  hamming_rx_deser dut (
    .clk        (clk),
    .RST        (RST),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .sof        (sof),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .syndrome   (syndrome),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [PAR_W-1:0]  syn;
    logic              corr;
    logic              uncorr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [PAR_W-1:0] s,
                      input logic c, input logic u);
    exp_t e;
    e.data = d; e.syn = s; e.corr = c; e.uncorr = u;
    sb.push_back(e);
  endtask

  // Monitor: compare the head entry every cycle the word is presented; this
  // also proves the outputs hold steady while out_ready is low.
  always @(negedge clk) begin
    if (RST && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb[0];
        chk("data_out",   32'(data_out),   32'(mon_e.data));
        chk("syndrome",   32'(syndrome),   32'(mon_e.syn));
        chk("err_corr",   32'(err_corr),   32'(mon_e.corr));
        chk("err_uncorr", 32'(err_uncorr), 32'(mon_e.uncorr));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic send_bit(input logic b, input logic s);
    ser_in = b; ser_valid = 1'b1; sof = s;
    @(posedge clk); #1;
    ser_valid = 1'b0; sof = 1'b0; ser_in = 1'b0;
  endtask

  task automatic send_word(input logic [CODE_W-1:0] w, input bit use_sof);
    for (int unsigned i = 0; i < CODE_W; i++) send_bit(w[i], use_sof && i == 0);
    chk("lat_after_last_bit", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_check_edge", 32'(out_valid), 32'd1);
  endtask

  task automatic send_frame(input logic [14:0] clean, input logic [14:0] err, input bit use_sof);
    logic [CODE_W-1:0] w;
`ifdef HAMMING_SECDED_EN
    w = {^clean, clean ^ err};
`else
    w = clean ^ err;
`endif
    send_word(w, use_sof);
  endtask

  task automatic wait_ready();
    int unsigned n;
    n = 0;
    while (!ser_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ser_ready_wait", 32'(ser_ready), 32'd1);
  endtask

  initial begin
    RST = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out",   32'(data_out),   32'd0);
    chk("rst_syndrome",   32'(syndrome),   32'd0);
    chk("rst_err_corr",   32'(err_corr),   32'd0);
    chk("rst_err_uncorr", 32'(err_uncorr), 32'd0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_ser_ready",  32'(ser_ready),  32'd1);
    RST = 1'b1;

    // all ones: valid codeword, syndrome 1^2^...^15 = 0
    push(11'h7FF, 4'd0, 1'b0, 1'b0);
    send_frame(15'h7FFF, 15'h0000, 1'b1);
    wait_ready();

    // zero word with position 5 flipped
    push(11'h000, 4'd5, 1'b1, 1'b0);
    send_frame(15'h0000, 15'h0010, 1'b1);
    wait_ready();

    // parity bit at position 1 flipped: data unaffected, still flagged
    push(11'h7FF, 4'd1, 1'b1, 1'b0);
    send_frame(15'h7FFF, 15'h0001, 1'b1);
    wait_ready();

    // data 0x001 -> positions 1,2,3; error at position 12; consumer stalls
    out_ready = 1'b0;
    push(11'h001, 4'd12, 1'b1, 1'b0);
    send_frame(15'h0007, 15'h0800, 1'b1);
    for (int i = 0; i < 5; i++) begin
      ser_in = 1'b1; ser_valid = 1'b1; sof = 1'b0;
      chk("hold_ser_ready", 32'(ser_ready), 32'd0);
      @(posedge clk); #1;
    end
    ser_valid = 1'b0; ser_in = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_out_valid", 32'(out_valid), 32'd0);
    chk("hold_release_ser_ready", 32'(ser_ready), 32'd1);

    // no sof: any bit leaked in during the stall would misalign this frame.
    // data 0x400 -> positions 1,2,4,8,15; error at position 15
    push(11'h400, 4'd15, 1'b1, 1'b0);
    send_frame(15'h408B, 15'h4000, 1'b0);
    wait_ready();

    // seven junk bits, then a fresh sof frame
    for (int i = 0; i < 7; i++) send_bit(1'b0, i == 0);
    push(11'h7FF, 4'd0, 1'b0, 1'b0);
    send_frame(15'h7FFF, 15'h0000, 1'b1);
    wait_ready();

    // reset mid-frame
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    RST = 1'b0;
    @(posedge clk); #1;
    chk("midrst_data_out",   32'(data_out),   32'd0);
    chk("midrst_syndrome",   32'(syndrome),   32'd0);
    chk("midrst_err_corr",   32'(err_corr),   32'd0);
    chk("midrst_err_uncorr", 32'(err_uncorr), 32'd0);
    chk("midrst_out_valid",  32'(out_valid),  32'd0);
    chk("midrst_ser_ready",  32'(ser_ready),  32'd1);
    RST = 1'b1;
    push(11'h400, 4'd0, 1'b0, 1'b0);
    send_frame(15'h408B, 15'h0000, 1'b0);
    wait_ready();

`ifdef HAMMING_SECDED_EN
    // positions 1 and 2 flipped: overall parity still even -> double error
    push(11'h7FF, 4'd3, 1'b0, 1'b1);
    send_word(16'hFFFC, 1'b1);
    wait_ready();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
